// File: rtl/sim_mem_arb_if.sv
// Requester and memory-pin bundle for sim_mem_arb.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface sim_mem_arb_if #(
    parameter int NREQ   = 2,
    parameter int WIDTH  = 36,
    parameter int NBYTES = 1,
    parameter int AW     = 1
);
    logic [NREQ-1:0]                req;
    logic [NREQ-1:0]                rq_we;
    logic [NREQ-1:0][AW-1:0]        rq_addr;
    logic [NREQ-1:0][WIDTH-1:0]     rq_din;
    logic [NREQ-1:0][NBYTES-1:0]    rq_wea;
    logic [NREQ-1:0]                ack;
    logic [WIDTH-1:0]               rdata;
    logic                           rvalid;
    logic [AW-1:0]                  mem_addr;
    logic [WIDTH-1:0]               mem_din;
    logic                           mem_oe;
    logic [NBYTES-1:0]              mem_wea;
    logic [WIDTH-1:0]               mem_dout;

    modport slave (
        input  req, rq_we, rq_addr, rq_din, rq_wea, mem_dout,
        output ack, rdata, rvalid, mem_addr, mem_din, mem_oe, mem_wea
    );

    modport master (
        output req, rq_we, rq_addr, rq_din, rq_wea, mem_dout,
        input  ack, rdata, rvalid, mem_addr, mem_din, mem_oe, mem_wea
    );
endinterface

// File: rtl/sim_mem_arb.sv
// Shares one sim_mem between NREQ requesters: IDLE -> ACCESS -> RESP, one op per 3 cycles.
// Define SIM_MEM_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module sim_mem_arb #(
    parameter int NREQ   = 2,
    parameter int SIZE   = 0,
    parameter int WIDTH  = 36,
    parameter int NBYTES = 1
) (
    input  logic          clk,
    input  logic          reset,
    sim_mem_arb_if.slave  bus
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e              state_q;
    logic [IW-1:0]       idx_q;
    logic                we_q;
    logic [AW-1:0]       addr_q;
    logic [WIDTH-1:0]    din_q;
    logic [NBYTES-1:0]   wea_q;
    logic [NREQ-1:0]     ack_q;
    logic                rvalid_q;
    logic [WIDTH-1:0]    rdata_q;
`ifdef SIM_MEM_ARB_RR_EN
    logic [IW-1:0]       last_q;
`endif

    logic [IW-1:0]       grant_d;
    logic                any_d;

    // Winner selection over the live request vector
    always_comb begin
        grant_d = {IW{1'b0}};
        any_d   = 1'b0;
`ifdef SIM_MEM_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (!any_d && bus.req[(int'(last_q) + k) % NREQ]) begin
                any_d   = 1'b1;
                grant_d = IW'((int'(last_q) + k) % NREQ);
            end else begin
                any_d   = any_d;
            end
        end
`else
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                any_d   = 1'b1;
                grant_d = IW'(k);
            end else begin
                any_d   = any_d;
            end
        end
`endif
    end

    // Sequencer: latch winner, run one memory cycle, pulse ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= {IW{1'b0}};
            we_q     <= 1'b0;
            addr_q   <= {AW{1'b0}};
            din_q    <= {WIDTH{1'b0}};
            wea_q    <= {NBYTES{1'b0}};
            ack_q    <= {NREQ{1'b0}};
            rvalid_q <= 1'b0;
            rdata_q  <= {WIDTH{1'b0}};
`ifdef SIM_MEM_ARB_RR_EN
            last_q   <= IW'(NREQ - 1);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        idx_q   <= grant_d;
                        we_q    <= bus.rq_we[grant_d];
                        addr_q  <= bus.rq_addr[grant_d];
                        din_q   <= bus.rq_din[grant_d];
                        wea_q   <= bus.rq_wea[grant_d];
                        state_q <= ACCESS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    ack_q    <= {{(NREQ-1){1'b0}}, 1'b1} << idx_q;
                    rvalid_q <= ~we_q;
                    if (!we_q) begin
                        rdata_q <= bus.mem_dout;
                    end else begin
                        rdata_q <= rdata_q;
                    end
                    state_q  <= RESP;
                end
                RESP: begin
                    ack_q    <= {NREQ{1'b0}};
                    rvalid_q <= 1'b0;
`ifdef SIM_MEM_ARB_RR_EN
                    last_q   <= idx_q;
`endif
                    state_q  <= IDLE;
                end
                default: begin
                    ack_q    <= {NREQ{1'b0}};
                    rvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode straight from state so a write in flight at reset still lands
    assign bus.mem_oe   = (state_q == ACCESS) && !we_q;
    assign bus.mem_wea  = ((state_q == ACCESS) && we_q) ? wea_q : {NBYTES{1'b0}};
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.ack      = ack_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_sim_mem_arb.sv
// Scoreboard bench for sim_mem_arb with a behavioural byte-lane sim_mem attached.
module tb_sim_mem_arb;
    localparam int NREQ   = 2;
    localparam int SIZE   = 16;
    localparam int WIDTH  = 36;
    localparam int NBYTES = 4;
    localparam int AW     = 4;
    localparam int LW     = WIDTH / NBYTES;

    typedef struct {
        int               idx;
        bit               rd;
        logic [WIDTH-1:0] data;
    } exp_t;

    typedef struct {
        int                lat;
        bit                to;
        logic [NREQ-1:0]   ack;
        logic              rv;
        logic [WIDTH-1:0]  rd;
        logic              oe;
        logic [NBYTES-1:0] wea;
        logic [AW-1:0]     addr;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [WIDTH-1:0] mem_arr [SIZE];
    logic [WIDTH-1:0] ref_mem [SIZE];

    sim_mem_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .NBYTES(NBYTES), .AW(AW)) bus ();

    sim_mem_arb #(.NREQ(NREQ), .SIZE(SIZE), .WIDTH(WIDTH), .NBYTES(NBYTES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural sim_mem: per-lane synchronous write, combinational read gated by oe
    always @(posedge clk) begin
        for (int b = 0; b < NBYTES; b++) begin
            if (bus.mem_wea[b]) mem_arr[bus.mem_addr][b*LW +: LW] <= bus.mem_din[b*LW +: LW];
        end
    end
    assign bus.mem_dout = bus.mem_oe ? mem_arr[bus.mem_addr] : {WIDTH{1'b0}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int r, input bit we, input logic [AW-1:0] a,
                            input logic [WIDTH-1:0] d, input logic [NBYTES-1:0] w);
        exp_t e;
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (w[b]) ref_mem[a][b*LW +: LW] = d[b*LW +: LW];
            end
        end
        e.idx  = r;
        e.rd   = !we;
        e.data = we ? {WIDTH{1'b0}} : ref_mem[a];
        exp_q.push_back(e);
    endtask

    task automatic drive_req(input int r, input bit we, input logic [AW-1:0] a,
                             input logic [WIDTH-1:0] d, input logic [NBYTES-1:0] w);
        bus.rq_we[r]   = we;
        bus.rq_addr[r] = a;
        bus.rq_din[r]  = d;
        bus.rq_wea[r]  = w;
        bus.req[r]     = 1'b1;
    endtask

    // Issue one uncontested op and record what the DUT showed; no judging here
    task automatic run_op(input int r, input bit we, input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d, input logic [NBYTES-1:0] w, output obs_t o);
        push_exp(r, we, a, d, w);
        drive_req(r, we, a, d, w);
        o.to = 1'b1;
        o.lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 1) begin
                o.oe = bus.mem_oe; o.wea = bus.mem_wea; o.addr = bus.mem_addr;
            end
            if (bus.ack !== {NREQ{1'b0}}) begin
                o.lat = i; o.to = 1'b0;
                o.ack = bus.ack; o.rv = bus.rvalid; o.rd = bus.rdata;
                break;
            end
        end
        tick();
        bus.req[r] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (bus.ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack got %b want 00", bus.ack); end
        n_checks++; if (bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b want 0", bus.rvalid); end
        n_checks++; if (bus.rdata !== 36'o0) begin n_fail++; $display("FAIL reset_rdata got %o want 0", bus.rdata); end
        n_checks++; if (bus.mem_addr !== 4'd0) begin n_fail++; $display("FAIL reset_mem_addr got %0d want 0", bus.mem_addr); end
        n_checks++; if (bus.mem_din !== 36'o0) begin n_fail++; $display("FAIL reset_mem_din got %o want 0", bus.mem_din); end
        n_checks++; if (bus.mem_oe !== 1'b0) begin n_fail++; $display("FAIL reset_mem_oe got %b want 0", bus.mem_oe); end
        n_checks++; if (bus.mem_wea !== 4'b0000) begin n_fail++; $display("FAIL reset_mem_wea got %b want 0000", bus.mem_wea); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        obs_t o;
        exp_t e;
        run_op(0, 1'b1, 4'd5, 36'o123456701234, 4'b1111, o);
        e = exp_q.pop_front();
        n_checks++; if (o.to || o.lat != 2) begin n_fail++; $display("FAIL wr_latency got %0d (timeout %0b) want 2", o.lat, o.to); end
        n_checks++; if (o.ack !== (NREQ'(1) << e.idx)) begin n_fail++; $display("FAIL wr_ack got %b want %b", o.ack, NREQ'(1) << e.idx); end
        n_checks++; if (o.rv !== 1'b0) begin n_fail++; $display("FAIL wr_rvalid got %b want 0", o.rv); end
        n_checks++; if (o.wea !== 4'b1111 || o.oe !== 1'b0 || o.addr !== 4'd5) begin n_fail++; $display("FAIL wr_pins got wea=%b oe=%b addr=%0d want 1111/0/5", o.wea, o.oe, o.addr); end
        n_checks++; if (mem_arr[5] !== 36'o123456701234) begin n_fail++; $display("FAIL wr_mem got %o want 123456701234", mem_arr[5]); end
        run_op(0, 1'b0, 4'd5, 36'o0, 4'b0000, o);
        e = exp_q.pop_front();
        n_checks++; if (o.to || o.lat != 2) begin n_fail++; $display("FAIL rd_latency got %0d (timeout %0b) want 2", o.lat, o.to); end
        n_checks++; if (o.ack !== 2'b01) begin n_fail++; $display("FAIL rd_ack got %b want 01", o.ack); end
        n_checks++; if (o.rv !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid got %b want 1", o.rv); end
        n_checks++; if (o.rd !== e.data) begin n_fail++; $display("FAIL rd_data got %o want %o", o.rd, e.data); end
        n_checks++; if (o.oe !== 1'b1 || o.wea !== 4'b0000) begin n_fail++; $display("FAIL rd_pins got oe=%b wea=%b want 1/0000", o.oe, o.wea); end
        n_checks++; if (bus.rdata !== 36'o123456701234 || bus.rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_hold got %o rv=%b want 123456701234 rv=0", bus.rdata, bus.rvalid); end
    endtask

    task automatic test_byte_lanes();
        obs_t o;
        exp_t e;
        run_op(0, 1'b1, 4'd0, 36'o777777777777, 4'b1111, o);
        e = exp_q.pop_front();
        run_op(1, 1'b1, 4'd0, 36'o0, 4'b0100, o);
        e = exp_q.pop_front();
        n_checks++; if (o.ack !== 2'b10) begin n_fail++; $display("FAIL lane_ack got %b want 10", o.ack); end
        n_checks++; if (mem_arr[0] !== 36'o777000777777) begin n_fail++; $display("FAIL lane_mem got %o want 777000777777", mem_arr[0]); end
        run_op(0, 1'b0, 4'd0, 36'o0, 4'b0000, o);
        e = exp_q.pop_front();
        n_checks++; if (o.rd !== e.data || o.rv !== 1'b1) begin n_fail++; $display("FAIL lane_read got %o rv=%b want %o rv=1", o.rd, o.rv, e.data); end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        int nack = 0;
        int last_t = 0;
        bit drop0 = 1'b0;
        bit drop_all = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
`ifdef SIM_MEM_ARB_RR_EN
        push_exp(0, 1'b0, 4'd5, 36'o0, 4'b0000); push_exp(1, 1'b0, 4'd0, 36'o0, 4'b0000);
        push_exp(0, 1'b0, 4'd5, 36'o0, 4'b0000); push_exp(1, 1'b0, 4'd0, 36'o0, 4'b0000);
`else
        push_exp(0, 1'b0, 4'd5, 36'o0, 4'b0000); push_exp(0, 1'b0, 4'd5, 36'o0, 4'b0000);
        push_exp(1, 1'b0, 4'd0, 36'o0, 4'b0000); push_exp(1, 1'b0, 4'd0, 36'o0, 4'b0000);
`endif
        drive_req(0, 1'b0, 4'd5, 36'o0, 4'b0000);
        drive_req(1, 1'b0, 4'd0, 36'o0, 4'b0000);
        for (int t = 1; t <= 40 && nack < 4; t++) begin
            tick();
            if (drop0) begin bus.req[0] = 1'b0; drop0 = 1'b0; end
            if (bus.ack !== 2'b00) begin
                nack++;
                e = exp_q.pop_front();
                n_checks++; if (bus.ack !== (NREQ'(1) << e.idx) || bus.rdata !== e.data) begin n_fail++; $display("FAIL sim_grant%0d got ack=%b data=%o want ack=%b data=%o", nack, bus.ack, bus.rdata, NREQ'(1) << e.idx, e.data); end
                if (nack > 1) begin
                    n_checks++; if (t - last_t != 3) begin n_fail++; $display("FAIL sim_interval%0d got %0d want 3", nack, t - last_t); end
                end
                last_t = t;
`ifndef SIM_MEM_ARB_RR_EN
                if (nack == 2) drop0 = 1'b1;
`endif
                if (nack == 4) drop_all = 1'b1;
            end
        end
        n_checks++; if (!drop_all) begin n_fail++; $display("FAIL sim_count got %0d acks want 4", nack); end
        tick();
        bus.req = 2'b00;
        tick(); tick();
        exp_q.delete();
    endtask

    task automatic test_withdrawn();
        exp_t e;
        bit ack1_seen = 1'b0;
        bit oe_seen = 1'b0;
        push_exp(0, 1'b1, 4'd9, 36'o246024602460, 4'b1111);
        drive_req(0, 1'b1, 4'd9, 36'o246024602460, 4'b1111);
        tick();
        drive_req(1, 1'b0, 4'd9, 36'o0, 4'b0000);
        tick();
        e = exp_q.pop_front();
        n_checks++; if (bus.ack !== 2'b01) begin n_fail++; $display("FAIL wd_ack0 got %b want 01", bus.ack); end
        bus.req[1] = 1'b0;
        tick();
        bus.req[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus.ack[1] === 1'b1) ack1_seen = 1'b1;
            if (bus.mem_oe === 1'b1) oe_seen = 1'b1;
            tick();
        end
        n_checks++; if (ack1_seen || oe_seen) begin n_fail++; $display("FAIL wd_req1 got ack1=%b oe=%b want 0/0", ack1_seen, oe_seen); end
        n_checks++; if (mem_arr[9] !== 36'o246024602460) begin n_fail++; $display("FAIL wd_mem got %o want 246024602460", mem_arr[9]); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        obs_t o;
        push_exp(0, 1'b0, 4'd5, 36'o0, 4'b0000);
        drive_req(0, 1'b0, 4'd5, 36'o0, 4'b0000);
        tick(); tick();
        e = exp_q.pop_front();
        n_checks++; if (bus.ack !== 2'b01 || bus.rvalid !== 1'b1) begin n_fail++; $display("FAIL rm_resp got ack=%b rv=%b want 01/1", bus.ack, bus.rvalid); end
        reset = 1'b1;
        bus.req[0] = 1'b0;
        tick();
        n_checks++; if (bus.ack !== 2'b00 || bus.rvalid !== 1'b0 || bus.rdata !== 36'o0) begin n_fail++; $display("FAIL rm_clear got ack=%b rv=%b rdata=%o want 00/0/0", bus.ack, bus.rvalid, bus.rdata); end
        reset = 1'b0;
        drive_req(1, 1'b0, 4'd0, 36'o0, 4'b0000);
        run_op(0, 1'b0, 4'd5, 36'o0, 4'b0000, o);
        e = exp_q.pop_front();
        n_checks++; if (o.to || o.lat != 2 || o.ack !== 2'b01 || o.rd !== e.data) begin n_fail++; $display("FAIL rm_contest got lat=%0d ack=%b data=%o want 2/01/%o", o.lat, o.ack, o.rd, e.data); end
        run_op(1, 1'b0, 4'd0, 36'o0, 4'b0000, o);
        e = exp_q.pop_front();
        n_checks++; if (o.to || o.ack !== 2'b10 || o.rd !== e.data) begin n_fail++; $display("FAIL rm_second got ack=%b data=%o want 10/%o", o.ack, o.rd, e.data); end
    endtask

    task automatic test_reset_write();
        bit ack_seen = 1'b0;
        drive_req(0, 1'b1, 4'd7, 36'o525252525252, 4'b1111);
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (mem_arr[7] !== 36'o525252525252) begin n_fail++; $display("FAIL rw_mem got %o want 525252525252", mem_arr[7]); end
        reset = 1'b0;
        bus.req[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.ack !== 2'b00) ack_seen = 1'b1;
            tick();
        end
        n_checks++; if (ack_seen) begin n_fail++; $display("FAIL rw_ack got an ack want none"); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.req     = 2'b00;
        bus.rq_we   = 2'b00;
        bus.rq_addr = '0;
        bus.rq_din  = '0;
        bus.rq_wea  = '0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_simultaneous();
        test_withdrawn();
        test_reset_mid();
        test_reset_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sim_mem_arb.md
# sim_mem_arb

Synchronous arbiter and sequencer that shares one `sim_mem` instance between `NREQ` testbench requesters, such as the KL10 MBox-side model and the front-end loader. Each requester issues single-word read or write requests over a req/ack handshake. The arbiter grants one requester at a time, drives the memory's `addr`, `din`, `oe` and `wea` pins, and returns registered read data with a one-cycle acknowledge.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `SIZE`, 0: memory depth in words; must match the attached `sim_mem`.
- `WIDTH`, 36: word width in bits.
- `NBYTES`, 1: byte lanes; must match the attached `sim_mem`.
- `AW`: derived, `$clog2(SIZE)`.

Ports (clock and reset first):
- `clk` in 1: sole clock. All state changes on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in [0:NREQ-1]: request, one bit per requester.
- `rq_we` in [0:NREQ-1]: 1 = write, 0 = read.
- `rq_addr` in [0:NREQ-1][0:AW-1]: word address.
- `rq_din` in [0:NREQ-1][0:WIDTH-1]: write data.
- `rq_wea` in [0:NREQ-1][0:NBYTES-1]: byte-lane enables, used on writes only.
- `ack` out [0:NREQ-1]: one-cycle completion pulse.
- `rdata` out WIDTH: read data, valid while `rvalid`=1.
- `rvalid` out 1: high with `ack` when the completed operation was a read.
- `mem_addr` out AW: to `sim_mem.addr`.
- `mem_din` out WIDTH: to `sim_mem.din`.
- `mem_oe` out 1: to `sim_mem.oe`.
- `mem_wea` out NBYTES: to `sim_mem.wea`.
- `mem_dout` in WIDTH: from `sim_mem.dout`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - If any `req` bit is set, pick a winner.
  - Latch the winner's index, `rq_we`, `rq_addr`, `rq_din` and `rq_wea` into internal registers, then go to ACCESS.
  - If no request is pending, stay in IDLE.
- **ACCESS**
  - `mem_addr` and `mem_din` come from the latched registers.
  - Write: `mem_wea` = latched `rq_wea`, `mem_oe`=0. The memory commits the write on the edge that leaves ACCESS.
  - Read: `mem_oe`=1, `mem_wea`=0. `mem_dout` is captured into `rdata` on the edge that leaves ACCESS.
  - Always proceeds to RESP.
- **RESP**
  - `ack[winner]`=1 for exactly one cycle.
  - `rvalid`=1 if the operation was a read.
  - Update the last-granted index, then go to IDLE.
- **Memory pins outside ACCESS:** `mem_wea`=0 and `mem_oe`=0. `mem_addr` and `mem_din` hold their last latched values.
- **`rdata`:** holds its value until the next read completes.
- **Requester rules**
  - Hold `req` and all request fields stable from assertion until `ack` is sampled high.
  - Deassert `req`, or present a new request, from the edge that samples `ack`.
  - The arbiter never looks at a requester's fields except in IDLE.
- **Withdrawn requests:** a requester that drops `req` before it is granted is simply not selected. It gets no ack and no memory access.
- **Reset**
  - State goes to IDLE; `ack`, `rvalid`, `rdata`, `mem_*` outputs and latched registers all go to 0.
  - Last-granted is set to `NREQ-1`, so requester 0 has first priority.
- **Reset mid-operation**
  - Any pending ack is dropped.
  - If reset coincides with the edge leaving ACCESS on a write, the write still commits, because `mem_wea` is combinational from state.
  - No ack is issued for that write.

## Timing
- Request sampled at edge E0 (IDLE to ACCESS).
- ACCESS cycle runs between E0 and E1.
- `ack` is high between E1 and E2; the requester samples it at E2.
- The FSM re-samples `req` at E3.
- Latency: 2 cycles from sampled request to ack.
- Throughput: one operation per 3 cycles; back-to-back grants are separated by one IDLE cycle.
- Read data is the memory contents at `mem_addr` during ACCESS. A write and a read to the same address in consecutive grants returns the new data.

## Configuration
- `SIM_MEM_ARB_RR_EN` defined: round-robin arbitration. The winner is the first requesting index after last-granted, searching upward and wrapping at `NREQ-1`→0.
- Undefined: fixed priority. The lowest requesting index always wins, and last-granted is ignored.

## Test plan
- **Single write then read.** Requester 0 writes addr 5, data 36'o123456701234, wea=1, then reads addr 5. Required: `ack[0]` two cycles after each sampled request, and the read returns `rdata`=36'o123456701234 with `rvalid`=1.
- **Simultaneous requests.** `req`=2'b11 held continuously with `SIM_MEM_ARB_RR_EN` defined. Required: grants alternate 0,1,0,1 with one ack every 3 cycles. Undefined: requester 0 is serviced until it drops `req`, then requester 1 is serviced.
- **Byte lanes.** With `NBYTES`=4, `WIDTH`=36, fill addr 0 with 36'o777777777777, then write 0 with wea=4'b0100. Required: only lane 2 (bits 18..26) changes.
- **Withdrawn request.** Requester 1 raises `req` while requester 0 is in ACCESS, then drops it before IDLE. Required: no `ack[1]` and no access by requester 1.
- **Reset mid-operation.** Assert `reset` during RESP of a read. Required: `ack`=0 and `rvalid`=0 the next cycle, state is IDLE, and requester 0 wins the next contested grant.
- **Reset at the ACCESS exit edge of a write.** Required: memory holds the new word and no ack is issued.
